// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the cpu data bus: direction encoding, default widths
// and the address-decode result type.
package cpu_bus_pkg;

  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;

  typedef enum logic [1:0] {
    ACC_OK,
    ACC_MISALIGN,
    ACC_RANGE
  } acc_e;

endpackage

// File: rtl/data_bus_ram_if.sv
// CPU data bus as seen by a memory slave: request fields from the cpu,
// registered load data back.
interface data_bus_ram_if #(
  parameter int DATA_WIDTH = cpu_bus_pkg::BUS_DATA_W,
  parameter int ADDR_WIDTH = cpu_bus_pkg::BUS_ADDR_W
);
  logic                  cs;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] Data_BUS_WRITE;
  logic [DATA_WIDTH-1:0] Data_BUS_READ;

  modport master (
    output cs, wr_rd, ADDR, Data_BUS_WRITE,
    input  Data_BUS_READ
  );

  modport slave (
    input  cs, wr_rd, ADDR, Data_BUS_WRITE,
    output Data_BUS_READ
  );
endinterface

// File: rtl/data_bus_ram_sync_ram_1p.sv
// Single-port RAM with write enable and registered, read-enabled output;
// no reset so it maps onto block RAM.
module sync_ram_1p #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_BITS-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_bus_ram.sv
// Word-organised data memory slave on the cpu data bus: one access per cycle,
// one-cycle load latency, sticky fault capture and saturating access counters.
module data_bus_ram
  import cpu_bus_pkg::*;
#(
  parameter int                    DATA_WIDTH = BUS_DATA_W,
  parameter int                    ADDR_WIDTH = BUS_ADDR_W,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  data_bus_ram_if.slave         bus,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  logic [ADDR_WIDTH-1:0] offset;
  acc_e                  acc;
  logic                  live, wr_ok, rd_ok, fault;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic                  zero_q, zero_d;

  assign offset = bus.ADDR - BASE_ADDR;

  always_comb begin
    acc = ACC_OK;
    if (bus.ADDR[1:0] != 2'b00)                       acc = ACC_MISALIGN;
    else if (offset[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0) acc = ACC_RANGE;
  end

  // Accesses presented while reset is high are dropped entirely.
  assign live  = bus.cs && !reset;
  assign wr_ok = live && (bus.wr_rd == BUS_WRITE) && (acc == ACC_OK);
  assign rd_ok = live && (bus.wr_rd == BUS_READ)  && (acc == ACC_OK);
  assign fault = live && (acc != ACC_OK);

  sync_ram_1p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (DEPTH_LOG2)
  ) u_ram (
    .clk     (CLK),
    .we_i    (wr_ok),
    .re_i    (rd_ok),
    .addr_i  (offset[DEPTH_LOG2+1:2]),
    .wdata_i (bus.Data_BUS_WRITE),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    zero_d     = zero_q;
    if (fault) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = bus.ADDR;
      if (bus.wr_rd == BUS_READ) zero_d = 1'b1;
    end
    if (rd_ok) begin
      zero_d = 1'b0;
      if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
    end
    if (wr_ok && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      zero_q     <= 1'b1;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      zero_q     <= zero_d;
    end
  end

  // The RAM output register has no reset; zero_q masks it after reset and
  // after a faulting read until the next good read reloads it.
  assign bus.Data_BUS_READ = zero_q ? '0 : ram_rdata;
  assign err               = err_q;
  assign err_addr          = err_addr_q;
  assign rd_count          = rd_cnt_q;
  assign wr_count          = wr_cnt_q;

endmodule

// File: tb/tb_data_bus_ram.sv
// Randomized and directed checks of data_bus_ram against a word-array model,
// with a second 4-bit-counter instance sharing the same request stream.
module tb_data_bus_ram;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  data_bus_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus16 ();
  data_bus_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus4 ();

  assign bus4.cs             = bus16.cs;
  assign bus4.wr_rd          = bus16.wr_rd;
  assign bus4.ADDR           = bus16.ADDR;
  assign bus4.Data_BUS_WRITE = bus16.Data_BUS_WRITE;

  logic        err16, err4;
  logic [31:0] ea16, ea4;
  logic [15:0] rc16, wc16;
  logic [3:0]  rc4, wc4;

  data_bus_ram #(.CNT_WIDTH(16)) dut16 (
    .CLK(CLK), .reset(reset), .bus(bus16.slave),
    .err(err16), .err_addr(ea16), .rd_count(rc16), .wr_count(wc16)
  );

  data_bus_ram #(.CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .reset(reset), .bus(bus4.slave),
    .err(err4), .err_addr(ea4), .rd_count(rc4), .wr_count(wc4)
  );

  // Reference model: plain word array plus expected register values.
  logic [31:0] mem_m [int];
  logic [31:0] rd_m;
  bit          rd_known;
  bit          err_m;
  logic [31:0] ea_m;
  int          rc_m, wc_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic step(input bit rst, input bit cs, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
    bit ok;
    int idx;
    reset = rst;
    bus16.cs = cs;
    bus16.wr_rd = wr;
    bus16.ADDR = a;
    bus16.Data_BUS_WRITE = d;
    @(posedge CLK);
    #1;
    if (rst) begin
      rd_m = '0; rd_known = 1'b1; err_m = 1'b0; ea_m = '0; rc_m = 0; wc_m = 0;
    end else if (cs) begin
      ok  = (a % 4 == 0) && (a < 32'd4096);
      idx = int'(a / 4);
      if (ok && wr) begin
        mem_m[idx] = d;
        wc_m++;
      end else if (ok) begin
        rd_known = mem_m.exists(idx);
        if (rd_known) rd_m = mem_m[idx];
        rc_m++;
      end else begin
        if (!wr) begin rd_m = '0; rd_known = 1'b1; end
        if (!err_m) ea_m = a;
        err_m = 1'b1;
      end
    end
    if (rd_known) begin
      chk("rdata16", bus16.Data_BUS_READ, rd_m);
      chk("rdata4", bus4.Data_BUS_READ, rd_m);
    end
    chk("err", {err16, err4}, {err_m, err_m});
    chk("err_addr16", ea16, ea_m);
    chk("err_addr4", ea4, ea_m);
    chk("rd_count16", rc16, sat(rc_m, 65535));
    chk("wr_count16", wc16, sat(wc_m, 65535));
    chk("rd_count4", rc4, sat(rc_m, 15));
    chk("wr_count4", wc4, sat(wc_m, 15));
  endtask

  initial begin
    logic [31:0] a;
    int r;
    bus16.cs = 1'b0; bus16.wr_rd = 1'b0; bus16.ADDR = '0; bus16.Data_BUS_WRITE = '0;
    rd_m = '0; rd_known = 1'b0; err_m = 1'b0; ea_m = '0; rc_m = 0; wc_m = 0;

    // Reset, then write/read one word.
    step(1, 0, 0, 32'h0, 32'h0);
    chk("reset_rdata", bus16.Data_BUS_READ, 32'h0);
    chk("reset_rc", rc16, 0);
    step(0, 1, 1, 32'h10, 32'hDEADBEEF);
    step(0, 1, 0, 32'h10, 32'h0);
    chk("t1_data", bus16.Data_BUS_READ, 32'hDEADBEEF);
    chk("t1_wc", wc16, 1);
    chk("t1_rc", rc16, 1);
    chk("t1_err", err16, 0);

    // Back-to-back stream.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'(4 * i), 32'(i + 1));
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'(4 * i), 32'h0);
      chk("stream_data", bus16.Data_BUS_READ, 32'(i + 1));
    end

    // Misaligned write, then out-of-range read.
    step(0, 1, 1, 32'h13, 32'h55);
    chk("mis_err", err16, 1);
    chk("mis_addr", ea16, 32'h13);
    chk("mis_wc", wc16, 4);
    step(0, 1, 0, 32'h10, 32'h0);
    chk("mis_mem", bus16.Data_BUS_READ, 32'hDEADBEEF);
    step(0, 1, 0, 32'h1000, 32'h0);
    chk("oor_data", bus16.Data_BUS_READ, 32'h0);
    chk("oor_addr", ea16, 32'h13);

    // Reset in the same cycle as a write.
    step(0, 1, 1, 32'h20, 32'hCAFE);
    step(1, 1, 1, 32'h20, 32'h1234);
    chk("rst_err", err16, 0);
    chk("rst_wc", wc16, 0);
    chk("rst_rc", rc16, 0);
    step(0, 1, 0, 32'h20, 32'h0);
    chk("rst_drop", bus16.Data_BUS_READ, 32'hCAFE);

    // Saturation of the 4-bit counters.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h4, 32'h0);
    chk("sat4", rc4, 4'hF);
    chk("sat16", rc16, 21);

    // Idle hold with toggling request fields.
    step(0, 1, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, i[0], 32'h1003 + 32'(i * 8), 32'hFFFF_FFFF);
    chk("idle_data", bus16.Data_BUS_READ, 32'h1);
    chk("idle_rc", rc16, 22);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      a = 32'($urandom_range(0, 31)) * 4;
      else if (r < 90) a = 32'($urandom_range(0, 4095)) | 32'($urandom_range(1, 3));
      else             a = $urandom_range(32'h1000, 32'hFFFF_FFFC) & 32'hFFFF_FFFC;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
           $urandom_range(0, 1) == 1, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus_ram.md
Name: data_bus_ram

Overview:
- Word-organised synchronous data memory acting as the bus slave directly downstream of the cpu data bus (cs, wr_rd, ADDR, Data_BUS_WRITE in; Data_BUS_READ out).
- Services one load or store per cycle with fixed one-cycle read latency, matching the cpu's load timing.
- Flags and records misaligned or out-of-range accesses.
- Keeps saturating read/write transaction counters for bench observation.

Parameters:
- DATA_WIDTH, 32, bus data width in bits.
- ADDR_WIDTH, 32, bus byte-address width.
- DEPTH_LOG2, 10, log2 of the word count (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
- CNT_WIDTH, 16, width of the transaction counters.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  chip select; transaction valid this cycle.
- wr_rd  in  1  1 = write (store), 0 = read (load); ignored when cs=0.
- ADDR  in  ADDR_WIDTH  byte address.
- Data_BUS_WRITE  in  DATA_WIDTH  store data.
- Data_BUS_READ  out  DATA_WIDTH  registered load data.
- err  out  1  sticky error flag.
- err_addr  out  ADDR_WIDTH  ADDR of the first faulting access since reset.
- rd_count  out  CNT_WIDTH  accepted reads, saturating.
- wr_count  out  CNT_WIDTH  accepted writes, saturating.

Behaviour:
- One clock (CLK); reset is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: Data_BUS_READ=0, err=0, err_addr=0, rd_count=0, wr_count=0.
- RAM contents are not cleared by reset.
- Any access presented in a cycle where reset=1 is dropped: no write, no count, no error capture.
- Decode: offset = ADDR - BASE_ADDR. The access is in range when offset < 4*2^DEPTH_LOG2. The access is aligned when ADDR[1:0]=0. The word index is offset[DEPTH_LOG2+1:2].
- Valid write (cs=1, wr_rd=1, aligned, in range):
  - mem[index] <= Data_BUS_WRITE at the edge.
  - wr_count increments.
  - Data_BUS_READ holds its previous value.
- Valid read (cs=1, wr_rd=0, aligned, in range):
  - Data_BUS_READ <= mem[index] at the edge, so data is visible in the cycle after the request (latency 1).
  - rd_count increments.
- Read following a write to the same word in the next cycle returns the newly written data; no bypass path is needed.
- Faulting access (cs=1, misaligned or out of range):
  - No RAM write.
  - A faulting read drives Data_BUS_READ <= 0.
  - Counters are unchanged.
  - err <= 1.
  - err_addr <= ADDR only if err was 0 beforehand; the first fault wins, and later faults do not overwrite it.
- cs=0: no state changes; Data_BUS_READ holds its last value.
- Counters saturate at all-ones and never wrap.
- err is cleared only by reset.
- Back-to-back accesses every cycle are supported; there is no wait state and no ready signal.

Decomposition:
- Shared package (cpu_bus_pkg) holds:
  - BUS_WRITE=1'b1 and BUS_READ=1'b0 constants;
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - a decode-result enum {ACC_OK, ACC_MISALIGN, ACC_RANGE}.
- One sub-module is natural: sync_ram_1p, a single-port RAM with registered read and write enable, inferred as block RAM.
- Address decode, error capture and the counters stay in data_bus_ram.

Test Plan:
- Reset, write then read:
  - Stimulus: reset for 1 cycle; write 0xDEADBEEF to 0x10; next cycle read 0x10.
  - Required: Data_BUS_READ=0xDEADBEEF one cycle after the read; wr_count=1; rd_count=1; err=0.
- Back-to-back stream:
  - Stimulus: writes to 0x0, 0x4, 0x8 with data 1, 2, 3 on consecutive cycles; then reads of the same addresses on consecutive cycles.
  - Required: Data_BUS_READ shows 1, 2, 3 on consecutive cycles, each one cycle late.
- Misaligned write:
  - Stimulus: write 0x55 to 0x13.
  - Required: err=1; err_addr=0x13; mem[4] unchanged (read 0x10 still returns 0xDEADBEEF); wr_count unchanged.
  - Follow-up stimulus: out-of-range read at 0x1000.
  - Required: Data_BUS_READ=0; err_addr stays 0x13.
- Reset mid-operation:
  - Stimulus: assert reset in the same cycle as a write of 0x1234 to 0x20.
  - Required: counters and err return to 0; a subsequent read of 0x20 returns the pre-reset contents, not 0x1234.
- Counter saturation (CNT_WIDTH=4 instance):
  - Stimulus: 20 valid reads.
  - Required: rd_count stops at 0xF.
- Idle hold:
  - Stimulus: read 0x0 (data 1), then cs=0 for 5 cycles with ADDR and wr_rd toggling.
  - Required: Data_BUS_READ stays 1; counters unchanged.
